// File: rtl/jtag_dp_target.sv
// JTAG debug-port target: TAP controller, IR/DR scan chains and DP/AP access bridge.
// Ports: CLK/RESET system clock and sync reset; TCK/TMS/TDI/TDO JTAG pins
//        (oversampled on CLK); REQ_* valid/ready access request; RSP_* response
//        strobe; STICKYERR sticky error flag.
module jtag_dp_target #(
  parameter logic [31:0] IDCODE = 32'h4BA00477
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TCK,
  input  logic        TMS,
  input  logic        TDI,
  output logic        TDO,
  output logic [39:0] REQ_DATA,
  output logic        REQ_VALID,
  input  logic        REQ_READY,
  input  logic [34:0] RSP_DATA,
  input  logic        RSP_VALID,
  output logic        STICKYERR
);

  localparam logic [3:0] IR_DPACC  = 4'hA;
  localparam logic [3:0] IR_APACC  = 4'hB;
  localparam logic [3:0] IR_IDCODE = 4'hE;

  localparam logic [2:0] ACK_WAIT = 3'b001;
  localparam logic [2:0] ACK_OK   = 3'b010;
  localparam logic [2:0] STAT_OK  = 3'b100;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SH_DR,
    EX1_DR,
    PAU_DR,
    EX2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SH_IR,
    EX1_IR,
    PAU_IR,
    EX2_IR,
    UPD_IR
  } tap_t;

  // ---------------------------------------------------------------
  // Pin synchronizers and TCK edge detection
  // ---------------------------------------------------------------
  logic [1:0] tck_s;
  logic [1:0] tms_s;
  logic [1:0] tdi_s;
  logic       tck_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tck_s <= '0;
      tms_s <= '0;
      tdi_s <= '0;
      tck_q <= 1'b0;
    end else begin
      tck_s <= {tck_s[0], TCK};
      tms_s <= {tms_s[0], TMS};
      tdi_s <= {tdi_s[0], TDI};
      tck_q <= tck_s[1];
    end
  end

  logic tck_rise;
  logic tck_fall;
  logic tms;
  logic tdi;

  assign tck_rise = tck_s[1] & ~tck_q;
  assign tck_fall = ~tck_s[1] & tck_q;
  assign tms      = tms_s[1];
  assign tdi      = tdi_s[1];

  // ---------------------------------------------------------------
  // TAP next-state
  // ---------------------------------------------------------------
  tap_t tap;
  tap_t tap_nxt;

  always_comb begin
    tap_nxt = tap;
    unique case (tap)
      TLR:    tap_nxt = tms ? TLR    : RTI;
      RTI:    tap_nxt = tms ? SEL_DR : RTI;
      SEL_DR: tap_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: tap_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  tap_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: tap_nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: tap_nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: tap_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: tap_nxt = tms ? SEL_DR : RTI;
      SEL_IR: tap_nxt = tms ? TLR    : CAP_IR;
      CAP_IR: tap_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  tap_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: tap_nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: tap_nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: tap_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: tap_nxt = tms ? SEL_DR : RTI;
    endcase
  end

  // ---------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------
  logic [3:0] ir;
  logic       is_dp;
  logic       is_ap;
  logic       is_id;
  logic       is_acc;

  assign is_dp  = (ir == IR_DPACC);
  assign is_ap  = (ir == IR_APACC);
  assign is_id  = (ir == IR_IDCODE);
  assign is_acc = is_dp | is_ap;

  // ---------------------------------------------------------------
  // Transaction state seen by the scan side
  // ---------------------------------------------------------------
  logic        busy;
  logic [31:0] rdbuff;
  logic        rsp_take;
  logic        cap_busy;
  logic [31:0] cap_rd;
  logic [2:0]  cap_ack;

  // A response landing in the capture cycle is folded in immediately.
  assign rsp_take = RSP_VALID & busy & ~REQ_VALID;
  assign cap_busy = busy & ~rsp_take;
  assign cap_rd   = rsp_take ? RSP_DATA[34:3] : rdbuff;
  assign cap_ack  = cap_busy ? ACK_WAIT : ACK_OK;

  // ---------------------------------------------------------------
  // TAP, IR and DR scan registers, TDO
  // ---------------------------------------------------------------
  logic [3:0]  ir_sh;
  logic [34:0] dr_sh;
  logic        scan_wait;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tap       <= TLR;
      ir        <= IR_IDCODE;
      ir_sh     <= '0;
      dr_sh     <= '0;
      scan_wait <= 1'b0;
      TDO       <= 1'b0;
    end else begin
      if (tck_rise) begin
        tap <= tap_nxt;
        case (tap)
          CAP_IR: ir_sh <= 4'b0001;
          SH_IR:  ir_sh <= {tdi, ir_sh[3:1]};
          CAP_DR: begin
            unique case (1'b1)
              is_acc: begin
                dr_sh     <= {cap_rd, cap_ack};
                scan_wait <= cap_busy;
              end
              is_id:   dr_sh <= {3'b000, IDCODE};
              default: dr_sh <= '0;
            endcase
          end
          SH_DR: begin
            unique case (1'b1)
              is_acc:  dr_sh       <= {tdi, dr_sh[34:1]};
              is_id:   dr_sh[31:0] <= {tdi, dr_sh[31:1]};
              default: dr_sh[0]    <= tdi;
            endcase
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        unique case (1'b1)
          tap == SH_IR: TDO <= ir_sh[0];
          tap == SH_DR: TDO <= dr_sh[0];
          default:      TDO <= 1'b0;
        endcase
        if (tap == UPD_IR) ir <= ir_sh;
      end
      if (tap == TLR) ir <= IR_IDCODE;
    end
  end

  // ---------------------------------------------------------------
  // Request issue / response handling
  // ---------------------------------------------------------------
  logic        upd_fire;
  logic [39:0] req_nxt;
  logic        abort_clr;

  assign upd_fire = tck_fall & (tap == UPD_DR) & is_acc & ~scan_wait;
  assign req_nxt  = {dr_sh[34:3], 4'b0000, dr_sh[2:1], is_ap, dr_sh[0]};

  // DP write to ABORT (addr 0) with STKERRCLR (data bit 5) set.
  assign abort_clr = is_dp & ~dr_sh[0] & (dr_sh[2:1] == 2'b00) & dr_sh[8];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      REQ_VALID <= 1'b0;
      REQ_DATA  <= '0;
      busy      <= 1'b0;
      rdbuff    <= '0;
      STICKYERR <= 1'b0;
    end else begin
      if (REQ_VALID & REQ_READY) REQ_VALID <= 1'b0;
      if (rsp_take) begin
        busy   <= 1'b0;
        rdbuff <= RSP_DATA[34:3];
        if (RSP_DATA[2:0] != STAT_OK) STICKYERR <= 1'b1;
      end
      if (upd_fire) begin
        REQ_DATA  <= req_nxt;
        REQ_VALID <= 1'b1;
        busy      <= 1'b1;
        if (abort_clr) STICKYERR <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jtag_dp_target.md
JTAG_DP_TARGET -- requirements
Module: jtag_dp_target

Interface
REQ-001 Parameter: IDCODE, default 32'h4BA00477, value captured by the IDCODE scan chain.
REQ-002 CLK  input  1  single clock for all logic; CLK frequency SHALL be at least 4x the TCK frequency.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 TCK  input  1  JTAG clock, asynchronous to CLK.
REQ-005 TMS  input  1  JTAG mode select, asynchronous.
REQ-006 TDI  input  1  JTAG data in, asynchronous.
REQ-007 TDO  output  1  JTAG data out.
REQ-008 REQ_DATA  output  40  access request {DATA[31:0], ADDR[5:0], APnDP, RnW}.
REQ-009 REQ_VALID  output  1  request valid.
REQ-010 REQ_READY  input  1  consumer accepts the request.
REQ-011 RSP_DATA  input  35  response {DATA[31:0], STAT[2:0]}; STAT 3'b100 means OK.
REQ-012 RSP_VALID  input  1  single-cycle response strobe.
REQ-013 STICKYERR  output  1  set when any response carries STAT != 3'b100.

Function
REQ-014 TCK, TMS and TDI SHALL each pass through a 2-flop synchronizer; a TCK rise/fall event SHALL be one CLK cycle on a synchronized 0->1 / 1->0 transition.
REQ-015 The TAP SHALL implement all 16 IEEE 1149.1 states, advancing only on a TCK rise event per synchronized TMS.
REQ-016 Five consecutive TCK rises with TMS=1 SHALL reach Test-Logic-Reset from any state.
REQ-017 IR: 4 bits; SHALL be 4'hE (IDCODE) in Test-Logic-Reset; Capture-IR loads 4'b0001; shifting is LSB first; IR updates only in Update-IR.
REQ-018 Decode: 4'hA=DPACC, 4'hB=APACC, 4'hE=IDCODE; every other value SHALL select BYPASS.
REQ-019 Capture-DR: IDCODE loads IDCODE[31:0]; BYPASS loads 1'b0; DPACC/APACC load {RDBUFF[31:0], ACK[2:0]}.
REQ-020 ACK = 3'b001 (WAIT) if busy at Capture-DR, else 3'b010 (OK/FAULT); the captured ACK SHALL be latched as scan_wait.
REQ-021 Shift-DR SHALL shift TDI into the MSB of the selected chain (35/32/1 bits) on each TCK rise.
REQ-022 TDO SHALL update on the TCK fall event to the LSB of the active IR or DR shift register while in Shift-IR/Shift-DR, and SHALL be 0 otherwise.
REQ-023 Update-DR with DPACC/APACC and scan_wait=0 SHALL load REQ_DATA = {sh[34:3], 4'b0000, sh[2:1], IR==APACC, sh[0]}, assert REQ_VALID and set busy on the next CLK.
REQ-024 Update-DR with scan_wait=1 SHALL issue no request and SHALL leave RDBUFF unchanged.
REQ-025 REQ_VALID and REQ_DATA SHALL hold until a cycle with REQ_READY=1, after which REQ_VALID deasserts next cycle.
REQ-026 busy SHALL clear on the RSP_VALID cycle; RDBUFF <= RSP_DATA[34:3] on RSP_VALID.
REQ-027 RSP_VALID while not busy, or while REQ_VALID is still high, SHALL be ignored.
REQ-028 RSP_VALID with RSP_DATA[2:0] != 3'b100 SHALL set STICKYERR; STICKYERR clears only on RESET or an accepted DPACC write with ADDR[1:0]=0 and DATA[5]=1 (ABORT.STKERRCLR), cleared locally at request issue.
REQ-029 RSP_VALID on the same cycle as a Capture-DR SHALL yield ACK=OK with the new RDBUFF value.
REQ-030 Entering Test-Logic-Reset SHALL not abort a pending transaction; busy persists until RSP_VALID.

Reset
REQ-031 On RESET: TAP=Test-Logic-Reset, IR=4'hE, TDO=0, REQ_VALID=0, REQ_DATA=0, busy=0, scan_wait=0, RDBUFF=0, STICKYERR=0, synchronizers=0.
REQ-032 RESET mid-scan or mid-transaction SHALL discard all state; a later RSP_VALID SHALL be ignored.

Verification
REQ-033 After RESET, 5 TMS=1 clocks, then shift 32 DR bits -> TDO outputs 32'h4BA00477 LSB first.
REQ-034 IR=4'hA, DR shift {32'h12345678, A[3:2]=2'b01, RnW=0} -> REQ_DATA=40'h12345678_04, REQ_VALID held until REQ_READY.
REQ-035 IR=4'hB read, hold REQ_READY=0, rescan -> captured ACK=3'b001, no new request; REQ_READY=1, RSP_DATA={32'hCAFEF00D,3'b100} strobe, rescan -> ACK=3'b010, data 32'hCAFEF00D.
REQ-036 Response STAT=3'b001 -> STICKYERR=1; DPACC write DATA=32'h20 to ADDR 0 -> STICKYERR=0.
REQ-037 IR=4'h3 -> 1-bit bypass, TDI pattern appears on TDO delayed by one TCK.
REQ-038 RESET asserted mid Shift-DR with busy=1 -> all outputs at reset values; later RSP_VALID ignored.
